// File: rtl/uart_rx_dev.sv
// UART receiver (8N1, LSB first) behind the Bridge: one-byte receive buffer,
// status/control/divisor registers and a level interrupt.
module uart_rx_dev #(
   parameter int unsigned DIV_DEFAULT = 217,
   parameter int unsigned DIV_MIN     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   input  logic        rxd,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic        s1, rs, rs_d;
   logic [2:0]  fill;
   logic        fall;
   logic [15:0] div, divw, cnt;
   logic [2:0]  bitidx;
   logic [7:0]  shreg, rbuf;
   logic        valid, ovr, ferr, ren, ien;
   logic        rd_data, wr_stat, wr_ctrl, wr_div;
   logic        unused_wd;

   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < 16'(DIV_MIN)) ? 16'(DIV_MIN) : d;
   endfunction

   assign rd_data   = re & (addr == 2'd0);
   assign wr_stat   = we & (addr == 2'd1);
   assign wr_ctrl   = we & (addr == 2'd2);
   assign wr_div    = we & (addr == 2'd3);
   assign unused_wd = ^wd[31:16];

   // Synchroniser stage: fill marks when rs_d holds a real line sample, so a
   // line already low at reset release is never mistaken for a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b1;
         rs   <= 1'b1;
         rs_d <= 1'b1;
         fill <= 3'b000;
      end else begin
         s1   <= rxd;
         rs   <= s1;
         rs_d <= rs;
         fill <= {fill[1:0], 1'b1};
      end
   end

   assign fall = fill[2] & rs_d & ~rs;

   always_ff @(posedge clk) begin
      if (reset) begin
         ren <= 1'b1;
         ien <= 1'b0;
         div <= 16'(DIV_DEFAULT);
      end else begin
         if (wr_ctrl) begin
            ren <= wd[0];
            ien <= wd[1];
         end
         if (wr_div) div <= wd[15:0];
      end
   end

   // Receive FSM stage: flag sets are written after the clears so a
   // coincident event wins over a write-1-to-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         bitidx <= '0;
         rbuf   <= '0;
         valid  <= 1'b0;
         ovr    <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         if (rd_data) valid <= 1'b0;
         if (wr_stat && wd[1]) ovr <= 1'b0;
         if (wr_stat && wd[2]) ferr <= 1'b0;

         if (!ren) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (fall) begin
                     divw  <= clamp_div(div);
                     cnt   <= clamp_div(div) >> 1;
                     state <= START;
                  end
               end
               START: begin
                  if (cnt != 16'd0) begin
                     cnt <= cnt - 16'd1;
                  end else if (!rs) begin
                     bitidx <= 3'd0;
                     cnt    <= divw - 16'd1;
                     state  <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end
               DATA: begin
                  if (cnt != 16'd0) begin
                     cnt <= cnt - 16'd1;
                  end else begin
                     shreg  <= {rs, shreg[7:1]};
                     cnt    <= divw - 16'd1;
                     bitidx <= bitidx + 3'd1;
                     if (bitidx == 3'd7) state <= STOP;
                  end
               end
               STOP: begin
                  if (cnt != 16'd0) begin
                     cnt <= cnt - 16'd1;
                  end else begin
                     state <= IDLE;
                     if (!rs) begin
                        ferr <= 1'b1;
                     end else if (!valid || rd_data) begin
                        rbuf  <= shreg;
                        valid <= 1'b1;
                     end else begin
                        ovr <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rd = '0;
      case (addr)
         2'd0: rd = {24'b0, rbuf};
         2'd1: rd = {29'b0, ferr, ovr, valid};
         2'd2: rd = {30'b0, ien, ren};
         2'd3: rd = {16'b0, div};
         default: rd = '0;
      endcase
   end

   assign irq = ien & (valid | ovr | ferr);

endmodule

// File: tb/tb_uart_rx_dev.sv
// Bench for uart_rx_dev: serial frames driven bit by bit against a register-level
// model of the receive buffer, flags and timing.
module tb_uart_rx_dev;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic        re;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        rxd;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic [7:0] m_rbuf;
   bit         m_valid, m_ovr, m_ferr, m_ren, m_ien;
   int         m_div;

   uart_rx_dev #(.DIV_DEFAULT(217), .DIV_MIN(4)) dut (
      .clk (clk), .reset (reset), .addr (addr), .we (we), .re (re),
      .wd (wd), .rd (rd), .rxd (rxd), .irq (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   function automatic void m_reset();
      m_rbuf = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0;
      m_ren = 1; m_ien = 0; m_div = 217;
   endfunction

   function automatic int m_divw();
      return (m_div < 4) ? 4 : m_div;
   endfunction

   function automatic logic [31:0] m_status();
      return {29'b0, m_ferr, m_ovr, m_valid};
   endfunction

   function automatic void m_frame(input logic [7:0] b, input bit stop_ok, input bit read_same);
      if (!stop_ok) m_ferr = 1;
      else if (!m_valid || read_same) begin m_rbuf = b; m_valid = 1; end
      else m_ovr = 1;
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk); addr = a; wd = d; we = 1'b1;
      @(negedge clk); we = 1'b0; addr = 2'd1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); addr = a; re = 1'b1; #1 d = rd;
      @(negedge clk); re = 1'b0; addr = 2'd1;
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); addr = a; #1 d = rd;
   endtask

   // Drives one frame with d cycles per bit while watching STATUS; lat is the
   // cycle (from the falling start edge) at which STATUS first changes.
   // act_kind: 1 = DATA read, 2 = register write, 3 = reset pulse, at cycle act_at.
   task automatic send_frame(input logic [7:0] b, input int d, input bit stop_ok,
                             input int act_at, input int act_kind,
                             input logic [1:0] act_addr, input logic [31:0] act_wd,
                             output int lat, output logic [31:0] rd_act);
      logic [9:0]  bits;
      logic [31:0] st0, st;
      int total;
      bits   = {stop_ok, b, 1'b0};
      total  = 12 * d + 8;
      lat    = -1;
      rd_act = '0;
      @(negedge clk); addr = 2'd1; we = 0; re = 0; reset = 0; #1 st0 = rd;
      for (int k = 0; k < total; k++) begin
         if (k > 0) begin
            @(negedge clk); addr = 2'd1; we = 0; re = 0; reset = 0; #1 st = rd;
            if (lat < 0 && st !== st0) lat = k;
         end
         rxd = (k < 10 * d) ? bits[k / d] : 1'b1;
         if (k == act_at) begin
            case (act_kind)
               1: begin addr = 2'd0; re = 1'b1; #1 rd_act = rd; end
               2: begin addr = act_addr; we = 1'b1; wd = act_wd; end
               3: reset = 1'b1;
               default: ;
            endcase
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1; rxd = 1;
      repeat (3) @(negedge clk);
      reset = 0; m_reset();
      peek(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL reset_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL reset_status: got %h want %h", v, m_status()); else n_pass++;
      peek(2'd2, v);
      n_checks++; if (v !== 32'h1) $display("FAIL reset_ctrl: got %h want %h", v, 32'h1); else n_pass++;
      peek(2'd3, v);
      n_checks++; if (v !== 32'd217) $display("FAIL reset_divr: got %h want %h", v, 32'd217); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
   endtask

   task automatic test_basic();
      logic [31:0] v, ra;
      logic [7:0]  b;
      int lat, dw, base;
      bus_write(2'd3, 32'hABCD_0010); m_div = 16;
      peek(2'd3, v);
      n_checks++; if (v !== 32'h10) $display("FAIL basic_divr_mask: got %h want %h", v, 32'h10); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            m_div = $urandom_range(5, 24);
            bus_write(2'd3, 32'(m_div));
         end
         b  = (i == 0) ? 8'hA5 : 8'($urandom);
         dw = m_divw();
         base = (dw >> 1) + 9 * dw;
         send_frame(b, dw, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra);
         m_frame(b, 1'b1, 1'b0);
         n_checks++; if (lat < base + 2 || lat > base + 4) $display("FAIL basic_latency: got %0d want %0d..%0d", lat, base + 2, base + 4); else n_pass++;
         peek(2'd1, v);
         n_checks++; if (v !== m_status()) $display("FAIL basic_status: got %h want %h", v, m_status()); else n_pass++;
         bus_read(2'd0, v);
         n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL basic_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
         m_valid = 0;
         peek(2'd1, v);
         n_checks++; if (v !== m_status()) $display("FAIL basic_valid_clr: got %h want %h", v, m_status()); else n_pass++;
      end
      m_div = 16;
      bus_write(2'd3, 32'd16);
   endtask

   task automatic test_overrun();
      logic [31:0] v, ra;
      int lat;
      send_frame(8'h11, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra); m_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra); m_frame(8'h22, 1'b1, 1'b0);
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ovr_status: got %h want %h", v, m_status()); else n_pass++;
      bus_write(2'd1, 32'h2); m_ovr = 0;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ovr_clear: got %h want %h", v, m_status()); else n_pass++;
      bus_read(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL ovr_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      m_valid = 0;
   endtask

   task automatic test_framing();
      logic [31:0] v, ra;
      int lat, base;
      base = 8 + 9 * 16;
      bus_write(2'd2, 32'h3); m_ien = 1;
      n_checks++; if (irq !== 1'b0) $display("FAIL ferr_irq_idle: got %b want 0", irq); else n_pass++;
      send_frame(8'h3C, 16, 1'b0, -1, 0, 2'd0, 32'h0, lat, ra);
      m_frame(8'h3C, 1'b0, 1'b0);
      n_checks++; if (lat < base + 2 || lat > base + 4) $display("FAIL ferr_latency: got %0d want %0d..%0d", lat, base + 2, base + 4); else n_pass++;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ferr_status: got %h want %h", v, m_status()); else n_pass++;
      peek(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL ferr_rbuf: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      n_checks++; if (irq !== 1'b1) $display("FAIL ferr_irq_set: got %b want 1", irq); else n_pass++;
      // second bad frame with a clear of both flags landing on the STOP sample
      send_frame(8'h3C, 16, 1'b0, base + 3, 2, 2'd1, 32'h6, lat, ra);
      m_ovr = 0; m_frame(8'h3C, 1'b0, 1'b0);
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ferr_set_wins: got %h want %h", v, m_status()); else n_pass++;
      bus_write(2'd1, 32'h4); m_ferr = 0;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ferr_clear: got %h want %h", v, m_status()); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL ferr_irq_clr: got %b want 0", irq); else n_pass++;
      bus_write(2'd2, 32'h1); m_ien = 0;
   endtask

   task automatic test_glitch();
      logic [31:0] v, ra;
      int lat, base;
      base = 8 + 9 * 16;
      @(negedge clk); rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL glitch_status: got %h want %h", v, m_status()); else n_pass++;
      send_frame(8'h5A, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra);
      m_frame(8'h5A, 1'b1, 1'b0);
      n_checks++; if (lat < base + 2 || lat > base + 4) $display("FAIL glitch_latency: got %0d want %0d..%0d", lat, base + 2, base + 4); else n_pass++;
      bus_read(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL glitch_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      m_valid = 0;
   endtask

   task automatic test_collision();
      logic [31:0] v, ra;
      logic [7:0]  b0, old;
      int lat, base;
      base = 8 + 9 * 16;
      b0 = 8'($urandom);
      send_frame(b0, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra); m_frame(b0, 1'b1, 1'b0);
      old = m_rbuf;
      send_frame(8'h77, 16, 1'b1, base + 3, 1, 2'd0, 32'h0, lat, ra);
      m_frame(8'h77, 1'b1, 1'b1);
      n_checks++; if (ra !== {24'b0, old}) $display("FAIL coll_read_val: got %h want %h", ra, {24'b0, old}); else n_pass++;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL coll_status: got %h want %h", v, m_status()); else n_pass++;
      bus_write(2'd1, 32'h1);
      bus_write(2'd0, 32'hFF);
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL coll_ro_status: got %h want %h", v, m_status()); else n_pass++;
      bus_read(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL coll_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      m_valid = 0;
   endtask

   task automatic test_control();
      logic [31:0] v, ra;
      logic [7:0]  b;
      int lat, base;
      b = 8'($urandom);
      send_frame(b, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra); m_frame(b, 1'b1, 1'b0);
      send_frame(8'($urandom), 16, 1'b1, 80, 2, 2'd2, 32'h0, lat, ra); m_ren = 0;
      send_frame(8'($urandom), 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra);
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL ctrl_abort_status: got %h want %h", v, m_status()); else n_pass++;
      peek(2'd2, v);
      n_checks++; if (v !== {30'b0, m_ien, m_ren}) $display("FAIL ctrl_ren_rb: got %h want %h", v, {30'b0, m_ien, m_ren}); else n_pass++;
      bus_write(2'd2, 32'h1); m_ren = 1;
      bus_read(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL ctrl_abort_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      m_valid = 0;
      // divisor below the minimum reads back as written but times at the minimum
      bus_write(2'd3, 32'h1); m_div = 1;
      peek(2'd3, v);
      n_checks++; if (v !== 32'h1) $display("FAIL ctrl_div1_rb: got %h want %h", v, 32'h1); else n_pass++;
      b = 8'($urandom);
      base = (m_divw() >> 1) + 9 * m_divw();
      send_frame(b, m_divw(), 1'b1, -1, 0, 2'd0, 32'h0, lat, ra); m_frame(b, 1'b1, 1'b0);
      n_checks++; if (lat < base + 2 || lat > base + 4) $display("FAIL ctrl_div1_latency: got %0d want %0d..%0d", lat, base + 2, base + 4); else n_pass++;
      bus_read(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL ctrl_div1_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      m_valid = 0;
      // reset in the middle of a frame whose line stays low past reset release
      bus_write(2'd3, 32'd16); m_div = 16;
      bus_write(2'd2, 32'h3);
      b = 8'($urandom) | 8'h01;
      send_frame(b, 16, 1'b1, -1, 0, 2'd0, 32'h0, lat, ra);
      send_frame(8'h00, 16, 1'b1, 35, 3, 2'd0, 32'h0, lat, ra);
      m_reset();
      repeat (2300) @(negedge clk);
      peek(2'd0, v);
      n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL rst_mid_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
      peek(2'd1, v);
      n_checks++; if (v !== m_status()) $display("FAIL rst_mid_status: got %h want %h", v, m_status()); else n_pass++;
      peek(2'd2, v);
      n_checks++; if (v !== 32'h1) $display("FAIL rst_mid_ctrl: got %h want %h", v, 32'h1); else n_pass++;
      peek(2'd3, v);
      n_checks++; if (v !== 32'd217) $display("FAIL rst_mid_divr: got %h want %h", v, 32'd217); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL rst_mid_irq: got %b want 0", irq); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] v, ra;
      logic [7:0]  b;
      bit ok;
      int lat, base;
      for (int i = 0; i < 6; i++) begin
         m_div = $urandom_range(1, 20);
         bus_write(2'd3, 32'(m_div));
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         base = (m_divw() >> 1) + 9 * m_divw();
         send_frame(b, m_divw(), ok, -1, 0, 2'd0, 32'h0, lat, ra);
         m_frame(b, ok, 1'b0);
         n_checks++; if (lat < base + 2 || lat > base + 4) $display("FAIL rand_latency: got %0d want %0d..%0d", lat, base + 2, base + 4); else n_pass++;
         peek(2'd1, v);
         n_checks++; if (v !== m_status()) $display("FAIL rand_status: got %h want %h", v, m_status()); else n_pass++;
         peek(2'd0, v);
         n_checks++; if (v !== {24'b0, m_rbuf}) $display("FAIL rand_data: got %h want %h", v, {24'b0, m_rbuf}); else n_pass++;
         bus_write(2'd1, 32'h6); m_ovr = 0; m_ferr = 0;
         bus_read(2'd0, v); m_valid = 0;
      end
   endtask

   initial begin
      reset = 1'b1; rxd = 1'b1; we = 1'b0; re = 1'b0; addr = 2'd1; wd = '0;
      m_reset();
      test_reset();
      repeat (5) @(negedge clk);
      test_basic();
      test_overrun();
      test_framing();
      test_glitch();
      test_collision();
      test_control();
      repeat (5) @(negedge clk);
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
